// File: rtl/stack_pkg.sv
// stack_front shared definitions.
// Delta encodings, FSM states and capacity helper.
package stack_pkg;

  localparam logic [1:0] DELTA_NONE = 2'b00;
  localparam logic [1:0] DELTA_PUSH = 2'b01;
  localparam logic [1:0] DELTA_POP  = 2'b11;
  localparam logic [1:0] DELTA_POP2 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    POP2 = 1'b1
  } state_e;

  // Memory entries plus the T register.
  function automatic int unsigned capacity(input int unsigned depth_log2);
    return (32'd1 << depth_log2) + 32'd1;
  endfunction

endpackage

// File: rtl/stack_front.sv
// Top-of-stack front end for a j1a stack.
// Holds T, tracks depth, drives memory push/pop strobes.
module stack_front
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_delta,
  input  logic             op_wr,
  input  logic [WIDTH-1:0] op_data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [DEPTH:0]   depth,
  output logic             empty,
  output logic             full,
  output logic             err_over,
  output logic             err_under,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout
);

  localparam logic [DEPTH:0] CAP = (DEPTH+1)'(capacity(DEPTH));
  localparam logic [DEPTH:0] ONE = (DEPTH+1)'(1);
  localparam logic [DEPTH:0] TWO = (DEPTH+1)'(2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [DEPTH:0]   depth_q, depth_d;
  logic             err_over_q, err_over_d;
  logic             err_under_q, err_under_d;
  logic             set_over, set_under;
  logic             full_w, empty_w;

  assign full_w    = (depth_q == CAP);
  assign empty_w   = (depth_q == '0);
  assign op_ready  = (state_q == IDLE);
  assign tos       = tos_q;
  assign depth     = depth_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign err_over  = err_over_q;
  assign err_under = err_under_q;
  assign stk_din   = tos_q;

  // Next-state, strobes and error detection for one op or POP2 step.
  always_comb begin
    state_d   = state_q;
    tos_d     = tos_q;
    depth_d   = depth_q;
    set_over  = 1'b0;
    set_under = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    if (state_q == POP2) begin
      state_d = IDLE;
      if (depth_q == ONE) begin
        tos_d   = '0;
        depth_d = '0;
      end else begin
        stk_pop = 1'b1;
        tos_d   = stk_dout;
        depth_d = depth_q - ONE;
      end
    end else if (op_valid) begin
      unique case (op_delta)
        DELTA_NONE: begin
          if (op_wr) begin
            tos_d = op_data;
            if (empty_w) depth_d = ONE;
          end
        end
        DELTA_PUSH: begin
          if (full_w) begin
            set_over = 1'b1;
          end else begin
            stk_push = !empty_w;
            tos_d    = op_data;
            depth_d  = depth_q + ONE;
          end
        end
        DELTA_POP: begin
          if (empty_w) begin
            set_under = 1'b1;
          end else if (depth_q == ONE) begin
            tos_d   = '0;
            depth_d = '0;
          end else begin
            stk_pop = 1'b1;
            tos_d   = stk_dout;
            depth_d = depth_q - ONE;
          end
        end
        DELTA_POP2: begin
          if (depth_q < TWO) begin
            set_under = 1'b1;
          end else begin
            stk_pop = 1'b1;
            depth_d = depth_q - ONE;
            state_d = POP2;
          end
        end
        default: ;
      endcase
    end
    err_over_d  = set_over | (err_over_q & ~clr_err);
    err_under_d = set_under | (err_under_q & ~clr_err);
  end

  // State registers with async active-low reset.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q     <= IDLE;
      tos_q       <= '0;
      depth_q     <= '0;
      err_over_q  <= 1'b0;
      err_under_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tos_q       <= tos_d;
      depth_q     <= depth_d;
      err_over_q  <= err_over_d;
      err_under_q <= err_under_d;
    end
  end

endmodule

// File: tb/tb_stack_front.sv
// Self-checking bench for stack_front.
// Queue reference model plus a behavioural stack memory.
module tb_stack_front;

  localparam int W   = 16;
  localparam int D   = 2;
  localparam int CAP = 5;

  logic          clk = 0;
  logic          resetq = 0;
  logic          op_valid = 0;
  logic          op_ready;
  logic [1:0]    op_delta = 0;
  logic          op_wr = 0;
  logic [W-1:0]  op_data = 0;
  logic          clr_err = 0;
  logic [W-1:0]  tos;
  logic [D:0]    depth;
  logic          empty, full, err_over, err_under;
  logic          stk_push, stk_pop;
  logic [W-1:0]  stk_din, stk_dout;

  int checks = 0;
  int failures = 0;

  stack_front #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .resetq(resetq),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_delta(op_delta), .op_wr(op_wr),
    .op_data(op_data), .clr_err(clr_err),
    .tos(tos), .depth(depth),
    .empty(empty), .full(full),
    .err_over(err_over), .err_under(err_under),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_din(stk_din), .stk_dout(stk_dout)
  );

  always #5 clk = ~clk;

  // Behavioural stack memory responding to the strobes.
  logic [W-1:0] mem [0:15];
  int sp;
  always @(posedge clk or negedge resetq) begin
    if (!resetq) sp <= 0;
    else if (stk_push && sp < 16) begin
      mem[sp] <= stk_din;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) sp <= sp - 1;
  end
  assign stk_dout = (sp > 0) ? mem[sp-1] : '0;

  // Reference model: whole stack contents, top at the back.
  logic [W-1:0] mdl[$];
  logic m_over, m_under;
  int exp_push, exp_pop, exp_busy;
  logic [W-1:0] exp_din;
  int n_push, n_pop, n_busy;
  logic [W-1:0] obs_din;

  function automatic logic [W-1:0] mtos();
    return (mdl.size() > 0) ? mdl[mdl.size()-1] : '0;
  endfunction

  task automatic model_op(input logic [1:0] d, input logic w,
                          input logic [W-1:0] data, input logic c);
    int sz;
    logic so, su;
    sz = mdl.size();
    so = 0; su = 0;
    exp_push = 0; exp_pop = 0; exp_busy = 0;
    exp_din = mtos();
    case (d)
      2'b00: if (w) begin
        if (sz == 0) mdl.push_back(data);
        else mdl[sz-1] = data;
      end
      2'b01: if (sz == CAP) so = 1;
        else begin
          exp_push = (sz > 0) ? 1 : 0;
          mdl.push_back(data);
        end
      2'b11: if (sz == 0) su = 1;
        else begin
          exp_pop = (sz >= 2) ? 1 : 0;
          void'(mdl.pop_back());
        end
      default: if (sz < 2) su = 1;
        else begin
          exp_busy = 1;
          exp_pop = (sz >= 3) ? 2 : 1;
          void'(mdl.pop_back());
          void'(mdl.pop_back());
        end
    endcase
    m_over  = so | (m_over & !c);
    m_under = su | (m_under & !c);
  endtask

  // Drive one op, record strobes, wait out any POP2 cycle.
  task automatic apply_op(input logic [1:0] d, input logic w,
                          input logic [W-1:0] data, input logic c);
    model_op(d, w, data, c);
    op_valid = 1; op_delta = d; op_wr = w;
    op_data = data; clr_err = c;
    #4;
    n_push = int'(stk_push);
    n_pop = int'(stk_pop);
    obs_din = stk_din;
    @(posedge clk); #1;
    op_valid = 0; op_wr = 0; clr_err = 0;
    n_busy = 0;
    while (!op_ready && n_busy < 4) begin
      n_busy++;
      #4;
      n_push += int'(stk_push);
      n_pop += int'(stk_pop);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    op_valid = 0; op_wr = 0; clr_err = 0;
    resetq = 0;
    mdl.delete();
    m_over = 0; m_under = 0;
    #3;
    resetq = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tos, depth, empty, full, err_over, err_under} !==
        {16'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got tos=%h depth=%0d e=%b f=%b o=%b u=%b",
               tos, depth, empty, full, err_over, err_under);
    end
    checks++;
    if ({op_ready, stk_push, stk_pop} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctl got rdy/push/pop=%b%b%b want 100",
               op_ready, stk_push, stk_pop);
    end
  endtask

  task automatic test_fill();
    int pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      apply_op(2'b01, 0, W'(i), 0);
      pulses += n_push;
      if (n_push > 0) begin
        checks++;
        if (obs_din !== W'(i-1)) begin
          failures++;
          $display("FAIL fill_din push %0d got %h want %h", i, obs_din, W'(i-1));
        end
      end
    end
    checks++;
    if (pulses != 4) begin
      failures++;
      $display("FAIL fill_pulses got %0d want 4", pulses);
    end
    checks++;
    if ({tos, depth, full} !== {16'h5, 3'd5, 1'b1}) begin
      failures++;
      $display("FAIL fill_state got tos=%h depth=%0d full=%b", tos, depth, full);
    end
    apply_op(2'b01, 0, 16'h6, 0);
    checks++;
    if ({err_over, tos, depth, 3'(n_push)} !== {1'b1, 16'h5, 3'd5, 3'd0}) begin
      failures++;
      $display("FAIL overflow got o=%b tos=%h depth=%0d push=%0d",
               err_over, tos, depth, n_push);
    end
  endtask

  task automatic test_drain();
    logic [W-1:0] want;
    for (int i = 0; i < 5; i++) begin
      apply_op(2'b11, 0, 16'h0, 0);
      want = (i < 4) ? W'(4 - i) : '0;
      checks++;
      if (tos !== want || n_pop !== ((i < 4) ? 1 : 0)) begin
        failures++;
        $display("FAIL drain_%0d got tos=%h pops=%0d want tos=%h",
                 i, tos, n_pop, want);
      end
    end
    checks++;
    if (empty !== 1'b1 || err_under !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty got empty=%b under=%b want 1 0", empty, err_under);
    end
    apply_op(2'b11, 0, 16'h0, 0);
    checks++;
    if (err_under !== 1'b1 || depth !== 3'd0) begin
      failures++;
      $display("FAIL drain_under got under=%b depth=%0d want 1 0", err_under, depth);
    end
  endtask

  task automatic test_double_pop();
    apply_op(2'b00, 0, 16'h0, 1);
    checks++;
    if ({err_over, err_under} !== 2'b00) begin
      failures++;
      $display("FAIL clear_both got %b%b want 00", err_over, err_under);
    end
    apply_op(2'b01, 0, 16'hA, 0);
    apply_op(2'b01, 0, 16'hB, 0);
    apply_op(2'b01, 0, 16'hC, 0);
    apply_op(2'b10, 0, 16'h0, 0);
    checks++;
    if (n_busy != 1 || n_pop != 2 || n_push != 0) begin
      failures++;
      $display("FAIL pop2_seq got busy=%0d pops=%0d push=%0d want 1 2 0",
               n_busy, n_pop, n_push);
    end
    checks++;
    if (tos !== 16'hA || depth !== 3'd1 || op_ready !== 1'b1) begin
      failures++;
      $display("FAIL pop2_state got tos=%h depth=%0d rdy=%b want a 1 1",
               tos, depth, op_ready);
    end
    apply_op(2'b10, 0, 16'h0, 0);
    checks++;
    if (err_under !== 1'b1 || depth !== 3'd1 || n_busy != 0 || n_pop != 0) begin
      failures++;
      $display("FAIL pop2_under got under=%b depth=%0d busy=%0d pops=%0d",
               err_under, depth, n_busy, n_pop);
    end
  endtask

  task automatic test_write();
    apply_op(2'b01, 0, 16'h0021, 0);
    apply_op(2'b01, 0, 16'h0022, 0);
    apply_op(2'b00, 1, 16'h1234, 0);
    checks++;
    if (tos !== 16'h1234 || depth !== 3'd3 || n_push + n_pop != 0) begin
      failures++;
      $display("FAIL write got tos=%h depth=%0d strobes=%0d want 1234 3 0",
               tos, depth, n_push + n_pop);
    end
    apply_op(2'b11, 0, 16'h0, 0);
    checks++;
    if (tos !== 16'h0021) begin
      failures++;
      $display("FAIL write_below got tos=%h want 0021", tos);
    end
  endtask

  task automatic test_err_clr();
    while (mdl.size() > 0) apply_op(2'b11, 0, 16'h0, 0);
    apply_op(2'b00, 0, 16'h0, 1);
    checks++;
    if (err_under !== 1'b0) begin
      failures++;
      $display("FAIL err_pre got under=%b want 0", err_under);
    end
    apply_op(2'b11, 0, 16'h0, 1);
    checks++;
    if (err_under !== 1'b1) begin
      failures++;
      $display("FAIL err_set_wins got under=%b want 1", err_under);
    end
    apply_op(2'b00, 0, 16'h0, 1);
    checks++;
    if (err_under !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got under=%b want 0", err_under);
    end
  endtask

  task automatic test_reset_pop2();
    apply_op(2'b01, 0, 16'h0031, 0);
    apply_op(2'b01, 0, 16'h0032, 0);
    apply_op(2'b01, 0, 16'h0033, 0);
    op_valid = 1; op_delta = 2'b10;
    @(posedge clk); #1;
    op_valid = 0;
    checks++;
    if (op_ready !== 1'b0 || stk_pop !== 1'b1) begin
      failures++;
      $display("FAIL pop2_enter got rdy=%b pop=%b want 0 1", op_ready, stk_pop);
    end
    #2;
    resetq = 0;
    #1;
    checks++;
    if ({depth, tos, op_ready, stk_pop, stk_push} !== {3'd0, 16'h0, 3'b100}) begin
      failures++;
      $display("FAIL reset_pop2 got depth=%0d tos=%h rdy=%b pop=%b push=%b",
               depth, tos, op_ready, stk_pop, stk_push);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [1:0] d;
    logic [W-1:0] dat;
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      d = (r < 4) ? 2'b01 : (r < 6) ? 2'b11 : (r < 8) ? 2'b00 : 2'b10;
      dat = W'($urandom);
      apply_op(d, 1'($urandom_range(0, 1)), dat, ($urandom_range(0, 15) == 0));
      checks++;
      if ({tos, depth, empty, full, err_over, err_under} !==
          {mtos(), 3'(mdl.size()), mdl.size() == 0,
           mdl.size() == CAP, m_over, m_under}) begin
        failures++;
        $display("FAIL rand_%0d state got tos=%h depth=%0d o=%b u=%b want tos=%h depth=%0d o=%b u=%b",
                 i, tos, depth, err_over, err_under,
                 mtos(), mdl.size(), m_over, m_under);
      end
      checks++;
      if (n_push != exp_push || n_pop != exp_pop || n_busy != exp_busy) begin
        failures++;
        $display("FAIL rand_%0d strobes got push=%0d pop=%0d busy=%0d want %0d %0d %0d",
                 i, n_push, n_pop, n_busy, exp_push, exp_pop, exp_busy);
      end
      if (exp_push == 1) begin
        checks++;
        if (obs_din !== exp_din) begin
          failures++;
          $display("FAIL rand_%0d din got %h want %h", i, obs_din, exp_din);
        end
      end
    end
  endtask

  initial begin
    m_over = 0; m_under = 0;
    test_reset();
    test_fill();
    test_drain();
    test_double_pop();
    test_write();
    test_err_clr();
    test_reset_pop2();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
